// File: rtl/wb_load_unit_pkg.sv
// Shared types and constants for the write-back load unit: load-size and
// error-code encodings, FSM states, zero constants and the alignment check.
package wb_load_unit_pkg;

   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic [63:0] ZERO_DWORD = 64'h0000_0000_0000_0000;

   typedef enum logic [1:0] {
      LSIZE_BYTE = 2'b00,
      LSIZE_HALF = 2'b01,
      LSIZE_WORD = 2'b10,
      LSIZE_RSVD = 2'b11
   } lsize_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_SIZE     = 2'b11
   } errcode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // A reserved size takes precedence over a misalignment report.
   function automatic errcode_e load_check(input logic [1:0] lsize, input logic [1:0] loff);
      if (lsize == LSIZE_RSVD)                    return ERR_SIZE;
      if (lsize == LSIZE_HALF && loff[0])         return ERR_MISALIGN;
      if (lsize == LSIZE_WORD && loff != 2'b00)   return ERR_MISALIGN;
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational extract/extend of load data. The memory word is first put
// into little-endian lane order, so byte/half selection is one indexed slice.
module wb_load_align
   import wb_load_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [31:0] dm,
   input  logic [1:0]  lsize,
   input  logic        lsign,
   input  logic [1:0]  loff,
   output logic [31:0] data
);

   logic [31:0] lanes;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // With byte 0 in the top lane, a full byte swap yields lane order 0..3 from LSB.
   assign lanes    = BIG_ENDIAN ? {dm[7:0], dm[15:8], dm[23:16], dm[31:24]} : dm;
   assign byte_sel = lanes[{loff, 3'b000} +: 8];
   assign half_sel = loff[1] ? lanes[31:16] : lanes[15:0];

   always_comb begin
      case (lsize)
         LSIZE_BYTE: data = {{24{lsign & byte_sel[7]}}, byte_sel};
         LSIZE_HALF: data = {{16{lsign & half_sel[15]}}, half_sel};
         default:    data = lanes;
      endcase
   end

endmodule

// File: rtl/wb_load_unit.sv
// Write-back stage with a blocking load wait (IDLE/WAIT FSM).
// Optional load-wait timeout is enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_load_unit
   import wb_load_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN     = 1'b1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        wb_valid_i,
   output logic        wb_ready_o,
   input  logic [4:0]  wb_wa_i,
   input  logic        wb_wreg_i,
   input  logic [31:0] wb_dreg_i,
   input  logic        wb_mreg_i,
   input  logic [1:0]  wb_lsize_i,
   input  logic        wb_lsign_i,
   input  logic [1:0]  wb_loff_i,
   input  logic        wb_whilo_i,
   input  logic [63:0] wb_hilo_i,
   input  logic        wb_flush_i,
   input  logic        dm_valid_i,
   input  logic [31:0] dm_i,
   output logic [4:0]  wb_wa_o,
   output logic        wb_wreg_o,
   output logic [31:0] wb_wd_o,
   output logic        wb_whilo_o,
   output logic [63:0] wb_hilo_o,
   output logic        wb_err_o,
   output logic [1:0]  wb_errcode_o
);

   state_e      state_q, state_d;
   logic [4:0]  wa_q;
   logic        wreg_q, lsign_q, whilo_q;
   logic [1:0]  lsize_q, loff_q;
   logic [63:0] hilo_q;

   logic [4:0]  wa_d;
   logic        wreg_d, whilo_d, err_d;
   logic [31:0] wd_d;
   logic [63:0] hilo_d;
   logic [1:0]  errcode_d;
   logic        accept, load_start, timeout;
   errcode_e    chk;
   logic [31:0] load_data;

   assign wb_ready_o = (state_q == ST_IDLE) && !cpu_rst;
   assign accept     = wb_valid_i && wb_ready_o && !wb_flush_i;
   assign chk        = load_check(wb_lsize_i, wb_loff_i);

   wb_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .dm    (dm_i),
      .lsize (lsize_q),
      .lsign (lsign_q),
      .loff  (loff_q),
      .data  (load_data)
   );

`ifdef WB_LOAD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst)                wait_cnt <= '0;
      else if (load_start)        wait_cnt <= '0;
      else if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
   end

   // Fires in the last of TIMEOUT_CYCLES cycles spent in WAIT.
   assign timeout = (state_q == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // No counter in this build; the constant compare keeps the parameter referenced.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      // NOTE: every combinational output is defaulted first so no latch is inferred.
      state_d    = state_q;
      wa_d       = wb_wa_o;
      wd_d       = wb_wd_o;
      hilo_d     = wb_hilo_o;
      errcode_d  = wb_errcode_o;
      wreg_d     = 1'b0;
      whilo_d    = 1'b0;
      err_d      = 1'b0;
      load_start = 1'b0;

      if (wb_flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (!wb_mreg_i) begin
                     wa_d    = wb_wa_i;
                     wreg_d  = wb_wreg_i && (wb_wa_i != 5'd0);
                     wd_d    = wb_dreg_i;
                     whilo_d = wb_whilo_i;
                     hilo_d  = wb_hilo_i;
                  end else if (chk != ERR_NONE) begin
                     err_d     = 1'b1;
                     errcode_d = chk;
                  end else begin
                     load_start = 1'b1;
                     state_d    = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (dm_valid_i) begin
                  wa_d    = wa_q;
                  wreg_d  = wreg_q && (wa_q != 5'd0);
                  wd_d    = load_data;
                  whilo_d = whilo_q;
                  hilo_d  = hilo_q;
                  state_d = ST_IDLE;
               end else if (timeout) begin
                  err_d     = 1'b1;
                  errcode_d = ERR_TIMEOUT;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q      <= ST_IDLE;
         wb_wa_o      <= '0;
         wb_wreg_o    <= 1'b0;
         wb_wd_o      <= ZERO_WORD;
         wb_whilo_o   <= 1'b0;
         wb_hilo_o    <= ZERO_DWORD;
         wb_err_o     <= 1'b0;
         wb_errcode_o <= ERR_NONE;
         wa_q         <= '0;
         wreg_q       <= 1'b0;
         lsize_q      <= LSIZE_BYTE;
         lsign_q      <= 1'b0;
         loff_q       <= 2'b00;
         whilo_q      <= 1'b0;
         hilo_q       <= ZERO_DWORD;
      end else begin
         state_q      <= state_d;
         wb_wa_o      <= wa_d;
         wb_wreg_o    <= wreg_d;
         wb_wd_o      <= wd_d;
         wb_whilo_o   <= whilo_d;
         wb_hilo_o    <= hilo_d;
         wb_err_o     <= err_d;
         wb_errcode_o <= errcode_d;
         if (load_start) begin
            wa_q    <= wb_wa_i;
            wreg_q  <= wb_wreg_i;
            lsize_q <= wb_lsize_i;
            lsign_q <= wb_lsign_i;
            loff_q  <= wb_loff_i;
            whilo_q <= wb_whilo_i;
            hilo_q  <= wb_hilo_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_load_unit.sv
// Scoreboard bench for wb_load_unit: a big-endian and a little-endian instance
// share stimulus; expected write-back events are queued and checked on output.
module tb_wb_load_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_wreg, wb_mreg, wb_lsign, wb_whilo, wb_flush, dm_valid;
   logic [4:0]  wb_wa;
   logic [31:0] wb_dreg, dm_data;
   logic [1:0]  wb_lsize, wb_loff;
   logic [63:0] wb_hilo;

   logic        be_ready, be_wreg, be_whilo, be_err;
   logic [4:0]  be_wa;
   logic [31:0] be_wd;
   logic [63:0] be_hilo;
   logic [1:0]  be_code;
   logic        le_ready, le_wreg, le_whilo, le_err;
   logic [4:0]  le_wa;
   logic [31:0] le_wd;
   logic [63:0] le_hilo;
   logic [1:0]  le_code;

   wb_load_unit #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(TMO)) dut_be (
      .cpu_clk_50M(clk), .cpu_rst(rst), .wb_valid_i(wb_valid), .wb_ready_o(be_ready),
      .wb_wa_i(wb_wa), .wb_wreg_i(wb_wreg), .wb_dreg_i(wb_dreg), .wb_mreg_i(wb_mreg),
      .wb_lsize_i(wb_lsize), .wb_lsign_i(wb_lsign), .wb_loff_i(wb_loff),
      .wb_whilo_i(wb_whilo), .wb_hilo_i(wb_hilo), .wb_flush_i(wb_flush),
      .dm_valid_i(dm_valid), .dm_i(dm_data), .wb_wa_o(be_wa), .wb_wreg_o(be_wreg),
      .wb_wd_o(be_wd), .wb_whilo_o(be_whilo), .wb_hilo_o(be_hilo),
      .wb_err_o(be_err), .wb_errcode_o(be_code)
   );

   wb_load_unit #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(TMO)) dut_le (
      .cpu_clk_50M(clk), .cpu_rst(rst), .wb_valid_i(wb_valid), .wb_ready_o(le_ready),
      .wb_wa_i(wb_wa), .wb_wreg_i(wb_wreg), .wb_dreg_i(wb_dreg), .wb_mreg_i(wb_mreg),
      .wb_lsize_i(wb_lsize), .wb_lsign_i(wb_lsign), .wb_loff_i(wb_loff),
      .wb_whilo_i(wb_whilo), .wb_hilo_i(wb_hilo), .wb_flush_i(wb_flush),
      .dm_valid_i(dm_valid), .dm_i(dm_data), .wb_wa_o(le_wa), .wb_wreg_o(le_wreg),
      .wb_wd_o(le_wd), .wb_whilo_o(le_whilo), .wb_hilo_o(le_hilo),
      .wb_err_o(le_err), .wb_errcode_o(le_code)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          due;
      bit          is_err;
      logic [1:0]  code;
      logic        wreg;
      logic [4:0]  wa;
      logic [31:0] wd_be;
      logic [31:0] wd_le;
      logic        whilo;
      logic [63:0] hilo;
   } exp_t;

   exp_t sbq[$];

   // Reference: gather the four memory bytes in address order, then assemble
   // the value with byte 0 as least significant.
   function automatic logic [31:0] ref_load(input bit be, input logic [31:0] dm,
                                            input logic [1:0] lsize, input logic lsign,
                                            input logic [1:0] loff);
      logic [7:0]  b [4];
      logic [15:0] h;
      for (int i = 0; i < 4; i++) b[i] = be ? dm[31-8*i -: 8] : dm[8*i +: 8];
      case (lsize)
         2'b00: return {{24{lsign & b[loff][7]}}, b[loff]};
         2'b01: begin
            h = {b[loff+1], b[loff]};
            return {{16{lsign & h[15]}}, h};
         end
         default: return {b[3], b[2], b[1], b[0]};
      endcase
   endfunction

   function automatic logic [1:0] ref_err(input logic [1:0] lsize, input logic [1:0] loff);
      if (lsize == 2'b11) return 2'b11;
      if ((lsize == 2'b01 && loff[0]) || (lsize == 2'b10 && loff != 2'b00)) return 2'b01;
      return 2'b00;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         check("be_err", be_err, e.is_err);
         check("le_err", le_err, e.is_err);
         if (e.is_err) begin
            check("be_code", be_code, e.code);
            check("le_code", le_code, e.code);
            check("err_no_write", {be_wreg, be_whilo, le_wreg, le_whilo}, 4'b0);
         end else begin
            check("be_wreg", be_wreg, e.wreg);
            check("le_wreg", le_wreg, e.wreg);
            check("be_wa", be_wa, e.wa);
            check("le_wa", le_wa, e.wa);
            check("be_wd", be_wd, e.wd_be);
            check("le_wd", le_wd, e.wd_le);
            check("be_whilo", be_whilo, e.whilo);
            check("le_whilo", le_whilo, e.whilo);
            if (e.whilo) begin
               check("be_hilo", be_hilo, e.hilo);
               check("le_hilo", le_hilo, e.hilo);
            end
         end
      end else begin
         check("no_pulse", {be_wreg, be_whilo, be_err, le_wreg, le_whilo, le_err}, 6'b0);
      end
   end

   logic [4:0]  p_wa;
   logic        p_wreg, p_lsign, p_whilo;
   logic [1:0]  p_lsize, p_loff;
   logic [63:0] p_hilo;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic mreg_v, input logic [4:0] wa, input logic wreg,
                       input logic [31:0] dreg, input logic [1:0] lsize, input logic lsign,
                       input logic [1:0] loff, input logic whilo, input logic [63:0] hilo);
      exp_t e;
      logic [1:0] code;
      code = ref_err(lsize, loff);
      wb_valid = 1'b1; wb_mreg = mreg_v; wb_wa = wa; wb_wreg = wreg; wb_dreg = dreg;
      wb_lsize = lsize; wb_lsign = lsign; wb_loff = loff; wb_whilo = whilo; wb_hilo = hilo;
      e = '{default: '0};
      e.due = cyc + 1;
      if (!mreg_v) begin
         e.wreg = wreg && (wa != 5'd0); e.wa = wa; e.wd_be = dreg; e.wd_le = dreg;
         e.whilo = whilo; e.hilo = hilo;
         sbq.push_back(e);
      end else if (code != 2'b00) begin
         e.is_err = 1'b1; e.code = code;
         sbq.push_back(e);
      end else begin
         p_wa = wa; p_wreg = wreg; p_lsize = lsize; p_lsign = lsign; p_loff = loff;
         p_whilo = whilo; p_hilo = hilo;
      end
      tick();
      wb_valid = 1'b0; wb_mreg = 1'b0; wb_whilo = 1'b0;
   endtask

   task automatic complete(input logic [31:0] dm);
      exp_t e;
      e = '{default: '0};
      e.due   = cyc + 1;
      e.wreg  = p_wreg && (p_wa != 5'd0);
      e.wa    = p_wa;
      e.wd_be = ref_load(1'b1, dm, p_lsize, p_lsign, p_loff);
      e.wd_le = ref_load(1'b0, dm, p_lsize, p_lsign, p_loff);
      e.whilo = p_whilo;
      e.hilo  = p_hilo;
      sbq.push_back(e);
      dm_valid = 1'b1; dm_data = dm;
      tick();
      dm_valid = 1'b0;
   endtask

   initial begin
      int c0;
      rst = 1'b1;
      wb_valid = 1'b0; wb_mreg = 1'b0; wb_wa = '0; wb_wreg = 1'b0; wb_dreg = '0;
      wb_lsize = '0; wb_lsign = 1'b0; wb_loff = '0; wb_whilo = 1'b0; wb_hilo = '0;
      wb_flush = 1'b0; dm_valid = 1'b0; dm_data = '0;
      repeat (2) tick();
      check("rst_ready", {be_ready, le_ready}, 2'b00);
      rst = 1'b0;
      tick();
      check("ready_after_rst", {be_ready, le_ready}, 2'b11);

      send(1'b0, 5'd3, 1'b1, 32'h1234_5678, 2'b00, 1'b0, 2'd0, 1'b1, 64'hDEAD_BEEF_0000_0001);
      send(1'b0, 5'd0, 1'b1, 32'hCAFE_F00D, 2'b00, 1'b0, 2'd0, 1'b0, 64'h0);
      tick();

      dm_valid = 1'b1; dm_data = 32'hFFFF_FFFF;
      tick();
      dm_valid = 1'b0;
      check("idle_dm_ready", {be_ready, le_ready}, 2'b11);

      // Signed byte at offset 1, data arrives three cycles after accept.
      send(1'b1, 5'd7, 1'b1, 32'h0, 2'b00, 1'b1, 2'd1, 1'b0, 64'h0);
      check("wait_ready_1", {be_ready, le_ready}, 2'b00);
      tick();
      check("wait_ready_2", {be_ready, le_ready}, 2'b00);
      tick();
      check("wait_ready_3", {be_ready, le_ready}, 2'b00);
      complete(32'h00F0_0000);
      check("ready_after_load", {be_ready, le_ready}, 2'b11);

      send(1'b1, 5'd9, 1'b1, 32'h0, 2'b01, 1'b0, 2'd2, 1'b0, 64'h0);
      tick();
      complete(32'h8001_0000);
      send(1'b1, 5'd11, 1'b1, 32'h0, 2'b01, 1'b1, 2'd0, 1'b0, 64'h0);
      complete(32'h0000_8000);
      send(1'b1, 5'd10, 1'b1, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 64'h0123_4567_89AB_CDEF);
      complete(32'h1122_3344);
      tick();

      send(1'b1, 5'd4, 1'b1, 32'h0, 2'b10, 1'b0, 2'd2, 1'b1, 64'h55);
      check("misalign_word_ready", {be_ready, le_ready}, 2'b11);
      send(1'b1, 5'd4, 1'b1, 32'h0, 2'b01, 1'b0, 2'd1, 1'b0, 64'h0);
      send(1'b1, 5'd4, 1'b1, 32'h0, 2'b11, 1'b0, 2'd0, 1'b0, 64'h0);
      check("rsvd_size_ready", {be_ready, le_ready}, 2'b11);
      tick();

      // Flush wins over data valid in the same cycle.
      send(1'b1, 5'd12, 1'b1, 32'h0, 2'b10, 1'b0, 2'd0, 1'b0, 64'h0);
      wb_flush = 1'b1; dm_valid = 1'b1; dm_data = 32'hA5A5_A5A5;
      tick();
      wb_flush = 1'b0; dm_valid = 1'b0;
      check("flush_idle", {be_ready, le_ready}, 2'b11);

      // Flush in IDLE blocks a presented instruction.
      wb_valid = 1'b1; wb_mreg = 1'b0; wb_wa = 5'd5; wb_wreg = 1'b1; wb_dreg = 32'h77;
      wb_flush = 1'b1;
      tick();
      wb_valid = 1'b0; wb_flush = 1'b0;
      check("flush_blocks_accept", {be_ready, le_ready}, 2'b11);
      tick();

`ifdef WB_LOAD_TIMEOUT_EN
      c0 = cyc;
      begin
         exp_t e;
         e = '{default: '0};
         e.due = c0 + 1 + TMO; e.is_err = 1'b1; e.code = 2'b10;
         sbq.push_back(e);
      end
      send(1'b1, 5'd13, 1'b1, 32'h0, 2'b10, 1'b0, 2'd0, 1'b0, 64'h0);
      check("tmo_wait_ready", {be_ready, le_ready}, 2'b00);
      repeat (TMO) tick();
      check("tmo_ready_at_err", {be_ready, le_ready}, 2'b11);
      tick();
      check("tmo_ready_after", {be_ready, le_ready}, 2'b11);
`else
      c0 = cyc;
      send(1'b1, 5'd13, 1'b1, 32'h0, 2'b10, 1'b0, 2'd0, 1'b0, 64'h0);
      repeat (80) tick();
      check("no_timeout_wait", {be_ready, le_ready}, 2'b00);
      check("no_timeout_span", cyc - c0 >= 80, 1'b1);
      wb_flush = 1'b1;
      tick();
      wb_flush = 1'b0;
      check("no_timeout_flush", {be_ready, le_ready}, 2'b11);
`endif

      // Asynchronous reset in the middle of a load wait.
      send(1'b1, 5'd14, 1'b1, 32'h0, 2'b00, 1'b0, 2'd0, 1'b0, 64'h0);
      #2 rst = 1'b1;
      #1;
      check("rst_be_wd", be_wd, 0);
      check("rst_le_wd", le_wd, 0);
      check("rst_be_hilo", be_hilo, 0);
      check("rst_le_hilo", le_hilo, 0);
      check("rst_be_ctl", {be_wa, be_wreg, be_whilo, be_err, be_code, be_ready}, 0);
      check("rst_le_ctl", {le_wa, le_wreg, le_whilo, le_err, le_code, le_ready}, 0);
      tick();
      rst = 1'b0;
      dm_valid = 1'b1; dm_data = 32'h1234_5678;
      tick();
      dm_valid = 1'b0;
      check("post_rst_ready", {be_ready, le_ready}, 2'b11);

      repeat (3) tick();
      check("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_load_unit.md
WB_LOAD_UNIT -- requirements
Module: wb_load_unit

Interface
REQ-001 SHALL take parameter BIG_ENDIAN, default 1; 1 = byte 0 in dm_i[31:24], 0 = byte 0 in dm_i[7:0].
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 64; the load-wait limit, in cycles.
REQ-003 SHALL use one clock, cpu_clk_50M; reset cpu_rst is asynchronous and active-high.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- cpu_clk_50M  in  1  clock.
- cpu_rst  in  1  async reset, active-high.
- wb_valid_i  in  1  instruction presented.
- wb_ready_o  out  1  unit can accept; upstream holds inputs while low.
- wb_wa_i  in  5  destination register.
- wb_wreg_i  in  1  register write enable.
- wb_dreg_i  in  32  execute result.
- wb_mreg_i  in  1  instruction is a load.
- wb_lsize_i  in  2  load size: 00 byte, 01 half, 10 word, 11 reserved.
- wb_lsign_i  in  1  1 = sign-extend, 0 = zero-extend.
- wb_loff_i  in  2  address bits [1:0].
- wb_whilo_i  in  1  HI/LO write enable.
- wb_hilo_i  in  64  HI/LO data.
- wb_flush_i  in  1  discard any pending load.
- dm_valid_i  in  1  memory read data valid.
- dm_i  in  32  memory read data.
- wb_wa_o, wb_wreg_o, wb_wd_o  out  5/1/32  register-file write port.
- wb_whilo_o, wb_hilo_o  out  1/64  HI/LO write port.
- wb_err_o  out  1  one-cycle error pulse.
- wb_errcode_o  out  2  error cause: 01 misaligned, 10 timeout, 11 reserved size.

Function
REQ-005 SHALL implement FSM IDLE/WAIT; wb_ready_o = (state==IDLE) && !cpu_rst.
REQ-006 Accept = wb_valid_i && wb_ready_o; non-load accept SHALL drive outputs registered one cycle later and stay in IDLE.
REQ-007 Non-load output: wb_wd_o = wb_dreg_i, wb_wreg_o = wb_wreg_i && (wb_wa_i != 0).
REQ-008 Load accept SHALL latch wa/wreg/lsize/lsign/loff/hilo fields and move IDLE->WAIT.
REQ-009 Misaligned load (half with loff[0]=1; word with loff != 00) or lsize = 11 SHALL be rejected at accept: no state change, wb_err_o pulses next cycle, no register write.
REQ-010 In WAIT, dm_valid_i SHALL extract the selected byte/half, sign- or zero-extend it to 32 bits, present it registered next cycle with wb_wreg_o, and return to IDLE.
REQ-011 A word load with BIG_ENDIAN=1 SHALL byte-reverse dm_i; with BIG_ENDIAN=0 it SHALL pass dm_i unchanged.
REQ-012 The HI/LO write of a load SHALL issue in the same cycle as its register write; for a non-load it issues at the REQ-006 timing.
REQ-013 All write enables and wb_err_o SHALL be single-cycle pulses; data outputs SHALL hold their value when idle.
REQ-014 dm_valid_i in IDLE SHALL be ignored.
REQ-015 wb_flush_i SHALL force IDLE next cycle with no writes; when flush and dm_valid_i occur together, flush wins; flush while in IDLE blocks that cycle's accept.

Reset
REQ-016 cpu_rst SHALL asynchronously force IDLE and zero every output, wb_ready_o included; a load pending mid-WAIT is dropped silently.

Configuration
REQ-017 With WB_LOAD_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT; once TIMEOUT_CYCLES cycles pass in WAIT without dm_valid_i, the unit SHALL go to IDLE and pulse wb_err_o with code 10, with no write.
REQ-018 Without WB_LOAD_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL persist indefinitely, and code 10 SHALL never occur.

Structure
REQ-019 The shared package/define file SHALL hold the lsize encodings, errcode values, FSM state encodings, and the existing ZERO_WORD/ZERO_DWORD constants.
REQ-020 The combinational extract/extend logic SHALL be a sub-module, wb_load_align (inputs dm, lsize, lsign, loff, BIG_ENDIAN; output 32-bit data).

Verification
REQ-021 Non-load with wa=3, dreg=0x12345678 -> next cycle wb_wreg_o=1, wb_wd_o=0x12345678; with wa=0 -> wb_wreg_o=0.
REQ-022 Signed byte load, loff=1, BIG_ENDIAN=1, dm_i=0x00F00000, dm_valid_i three cycles later -> wb_wd_o=0xFFFFFFF0; wb_ready_o low for 3 cycles.
REQ-023 Unsigned half load, loff=2, BIG_ENDIAN=0, dm_i=0x8001_0000 -> 0x00008001; word load, BIG_ENDIAN=1, dm_i=0x11223344 -> 0x44332211.
REQ-024 Word load with loff=2 -> wb_err_o=1, wb_errcode_o=01, wb_wreg_o=0, wb_ready_o stays 1.
REQ-025 WAIT with wb_flush_i and dm_valid_i asserted in the same cycle -> no write, IDLE next cycle; cpu_rst asserted mid-WAIT -> all outputs 0 immediately.
REQ-026 With WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, no dm_valid_i -> wb_errcode_o=10 pulse, wb_ready_o high on the following cycle.
